wir_ctrl: RTL and testbench
===========================

WIR_CTRL -- requirements
Module: wir_ctrl

Interface
REQ-001 Parameter CAP_VAL, default 3'b001, the value loaded into the WIR shift stage on capture.
REQ-002 Port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge only.
REQ-003 Port WRST, input, 1 bit, reset; asynchronous, active-high.
REQ-004 Port WSI, input, 1 bit, wrapper serial input.
REQ-005 Port SelectWIR, input, 1 bit; 1 selects the WIR path, 0 selects the data path (WBY or boundary chain).
REQ-006 Port ShiftWR, input, 1 bit, shift enable.
REQ-007 Port CaptureWR, input, 1 bit, capture enable.
REQ-008 Port UpdateWR, input, 1 bit, update enable.
REQ-009 Port wbr_so, input, 1 bit, serial output of the downstream 3-bit boundary shift register.
REQ-010 Port WSO, output, 1 bit, wrapper serial output.
REQ-011 Port wir_out, output, 3 bits, active instruction (the update stage).
REQ-012 Ports bypass_sel, extest_sel, intest_sel, output, 1 bit each, decoded instruction.
REQ-013 Port invalid, output, 1 bit, high when wir_out holds a reserved code.
REQ-014 Port len_err, output, 1 bit, shift-length error flag (present only per REQ-030).

Function
REQ-015 State: wir_sr[2:0] shift stage, wir_ur[2:0] update stage, wby (1 bit), cnt (3 bits, saturating at 4).
REQ-016 Capture: CaptureWR=1 and SelectWIR=1 SHALL load wir_sr<=CAP_VAL and clear cnt to 0.
REQ-017 Shift: ShiftWR=1, CaptureWR=0 and SelectWIR=1 SHALL perform wir_sr<={WSI,wir_sr[2:1]} and set cnt<=min(cnt+1,4).
REQ-018 Capture and shift asserted in the same cycle: capture SHALL take priority, and no shift or count increment SHALL occur.
REQ-019 Update: UpdateWR=1 and SelectWIR=1 SHALL load wir_ur<=wir_sr, using the pre-edge value, subject to REQ-030.
REQ-020 Update asserted in the same cycle as shift or capture: update SHALL use the pre-edge wir_sr while the shift stage advances normally.
REQ-021 Decode, combinational from wir_ur: 000 sets bypass_sel (WS_BYPASS); 001 sets extest_sel; 010 sets intest_sel.
REQ-022 Reserved codes 011 through 111 SHALL set invalid=1 and bypass_sel=1.
REQ-023 WBY, when SelectWIR=0 and bypass_sel=1: CaptureWR SHALL set wby<=0; otherwise ShiftWR SHALL set wby<=WSI.
REQ-024 WBY SHALL hold its value in every other case.
REQ-025 WSO, combinational: SelectWIR=1 selects wir_sr[0]; SelectWIR=0 with bypass_sel=1 selects wby; otherwise wbr_so.
REQ-026 Path latency: the WIR path SHALL be 3 clocks WSI-to-WSO; the bypass path SHALL be 1 clock.
REQ-027 With SelectWIR=0, wir_sr, wir_ur and cnt SHALL hold their values.
REQ-028 Shifting SHALL never alter wir_out until an update occurs.

Reset
REQ-029 WRST=1 SHALL immediately force wir_sr=000, wir_ur=000, wby=0, cnt=0 and len_err=0, giving bypass_sel=1, all other decode outputs 0, and WSO=0 when SelectWIR=1; reset asserted mid-shift SHALL discard the partial instruction, and the first edge after release SHALL operate normally.

Configuration
REQ-030 Macro WIR_LENCHK_EN, when defined: an update with cnt!=3 SHALL leave wir_ur unchanged and set len_err<=1; an update with cnt==3 SHALL load wir_ur and clear len_err; without the macro, every update SHALL load wir_ur, cnt logic SHALL be omitted, and len_err SHALL be tied to 0.

Verification
REQ-031 Scenario: reset, then idle -> wir_out=000, bypass_sel=1, invalid=0, len_err=0.
REQ-032 Scenario: SelectWIR=1, capture, shift WSI bits 1,0,0, then update -> wir_out=001, extest_sel=1; WSO during the 3 shift cycles shows CAP_VAL bits 1,0,0.
REQ-033 Scenario: shift in 111 and update -> invalid=1, bypass_sel=1.
REQ-034 Scenario: SelectWIR=0 with WS_BYPASS, WSI stream 1,0,1,1 -> WSO shows the same stream one clock later; with WS_INTEST active, WSO follows wbr_so.
REQ-035 Scenario: WIR_LENCHK_EN defined, capture, 2 shifts, update -> wir_out unchanged, len_err=1; then capture, 3 shifts, update -> new code loaded, len_err=0.
REQ-036 Scenario: WRST pulsed after 2 of 3 shifts -> wir_sr=000 and wir_out=000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wir_ctrl.sv
// wir_ctrl: wrapper instruction register (WIR) controller with bypass (WBY)
// and serial-output steering between WIR, WBY and the boundary chain.
// Optional shift-length checking is enabled by defining WIR_LENCHK_EN;
// without it every update loads the instruction and len_err is tied low.
module wir_ctrl #(
    parameter logic [2:0] CAP_VAL = 3'b001
) (
    input  logic       clk,
    input  logic       WRST,
    input  logic       WSI,
    input  logic       SelectWIR,
    input  logic       ShiftWR,
    input  logic       CaptureWR,
    input  logic       UpdateWR,
    input  logic       wbr_so,
    output logic       WSO,
    output logic [2:0] wir_out,
    output logic       bypass_sel,
    output logic       extest_sel,
    output logic       intest_sel,
    output logic       invalid,
    output logic       len_err
);

    logic [2:0] wir_sr_q, wir_sr_d;
    logic [2:0] wir_ur_q, wir_ur_d;
    logic       wby_q, wby_d;
    logic       upd_en;

    // Shift stage next state: capture wins over shift, both need SelectWIR
    always_comb begin
        wir_sr_d = wir_sr_q;
        if (SelectWIR) begin
            if (CaptureWR) begin
                wir_sr_d = CAP_VAL;
            end else if (ShiftWR) begin
                wir_sr_d = {WSI, wir_sr_q[2:1]};
            end
        end
    end

`ifdef WIR_LENCHK_EN
    logic [2:0] cnt_q, cnt_d;
    logic       len_err_q, len_err_d;

    // Shift counter (saturates at 4) and update gating on exactly 3 shifts
    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
        upd_en    = 1'b0;
        if (SelectWIR) begin
            if (CaptureWR) begin
                cnt_d = '0;
            end else if (ShiftWR && (cnt_q != 3'd4)) begin
                cnt_d = cnt_q + 3'd1;
            end
            if (UpdateWR) begin
                if (cnt_q == 3'd3) begin
                    upd_en    = 1'b1;
                    len_err_d = 1'b0;
                end else begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    // Counter and error flag registers
    always_ff @(posedge clk or posedge WRST) begin
        if (WRST) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign upd_en  = SelectWIR & UpdateWR;
    assign len_err = 1'b0;
`endif

    // Update stage and bypass next state; update samples the pre-edge shift stage
    always_comb begin
        wir_ur_d = upd_en ? wir_sr_q : wir_ur_q;
        wby_d    = wby_q;
        if (!SelectWIR && bypass_sel) begin
            if (CaptureWR) begin
                wby_d = 1'b0;
            end else if (ShiftWR) begin
                wby_d = WSI;
            end
        end
    end

    // WIR stages and bypass register
    always_ff @(posedge clk or posedge WRST) begin
        if (WRST) begin
            wir_sr_q <= '0;
            wir_ur_q <= '0;
            wby_q    <= 1'b0;
        end else begin
            wir_sr_q <= wir_sr_d;
            wir_ur_q <= wir_ur_d;
            wby_q    <= wby_d;
        end
    end

    // Instruction decode; reserved codes fall back to bypass
    always_comb begin
        bypass_sel = 1'b0;
        extest_sel = 1'b0;
        intest_sel = 1'b0;
        invalid    = 1'b0;
        case (wir_ur_q)
            3'b000:  bypass_sel = 1'b1;
            3'b001:  extest_sel = 1'b1;
            3'b010:  intest_sel = 1'b1;
            default: begin
                invalid    = 1'b1;
                bypass_sel = 1'b1;
            end
        endcase
    end

    // Serial output steering
    always_comb begin
        if (SelectWIR) begin
            WSO = wir_sr_q[0];
        end else if (bypass_sel) begin
            WSO = wby_q;
        end else begin
            WSO = wbr_so;
        end
    end

    assign wir_out = wir_ur_q;

endmodule

// File: tb/tb_wir_ctrl.sv
// tb_wir_ctrl: scoreboard bench for wir_ctrl with a queue-based reference model.
module tb_wir_ctrl;

    localparam logic [2:0] CAP = 3'b001;

    logic       clk = 1'b0;
    logic       WRST = 1'b1;
    logic       WSI = 1'b0;
    logic       SelectWIR = 1'b0;
    logic       ShiftWR = 1'b0;
    logic       CaptureWR = 1'b0;
    logic       UpdateWR = 1'b0;
    logic       wbr_so = 1'b0;
    logic       WSO;
    logic [2:0] wir_out;
    logic       bypass_sel, extest_sel, intest_sel, invalid, len_err;

    wir_ctrl #(.CAP_VAL(CAP)) dut (
        .clk(clk), .WRST(WRST), .WSI(WSI), .SelectWIR(SelectWIR),
        .ShiftWR(ShiftWR), .CaptureWR(CaptureWR), .UpdateWR(UpdateWR),
        .wbr_so(wbr_so), .WSO(WSO), .wir_out(wir_out),
        .bypass_sel(bypass_sel), .extest_sel(extest_sel),
        .intest_sel(intest_sel), .invalid(invalid), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wso;
        logic [2:0] wo;
        logic       byp, ext, intst, inv, le;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: shift stage as a bit queue, index 0 is the serial-out end
    bit       m_sr[$];
    int       m_ur;
    bit       m_wby;
    int       m_cnt;
    bit       m_le;

    function automatic int sr_val();
        return m_sr[0] + 2 * m_sr[1] + 4 * m_sr[2];
    endfunction

    function automatic bit is_bypass(int code);
        return (code == 0) || (code > 2);
    endfunction

    task automatic model_reset();
        m_sr = '{0, 0, 0};
        m_ur = 0; m_wby = 0; m_cnt = 0; m_le = 0;
    endtask

    task automatic model_step(input bit sel, sh, cap, upd, wsi);
        int pre_sr  = sr_val();
        int pre_cnt = m_cnt;
        logic [2:0] c = CAP;
        if (sel) begin
            if (cap) begin
                m_sr.delete();
                for (int i = 0; i < 3; i++) m_sr.push_back(c[i]);
                m_cnt = 0;
            end else if (sh) begin
                void'(m_sr.pop_front());
                m_sr.push_back(wsi);
                m_cnt = (pre_cnt + 1 > 4) ? 4 : pre_cnt + 1;
            end
            if (upd) begin
`ifdef WIR_LENCHK_EN
                if (pre_cnt == 3) begin m_ur = pre_sr; m_le = 0; end
                else m_le = 1;
`else
                m_ur = pre_sr;
`endif
            end
        end else if (is_bypass(m_ur)) begin
            if (cap) m_wby = 0;
            else if (sh) m_wby = wsi;
        end
    endtask

    function automatic exp_t expect_now(input bit sel, wbr);
        exp_t e;
        e.wo    = m_ur[2:0];
        e.byp   = is_bypass(m_ur);
        e.ext   = (m_ur == 1);
        e.intst = (m_ur == 2);
        e.inv   = (m_ur > 2);
        e.le    = m_le;
        e.wso   = sel ? m_sr[0] : (e.byp ? m_wby : wbr);
        return e;
    endfunction

    // Driver: applies one cycle of inputs and queues the expected outputs
    task automatic drive(input bit rst, sel, sh, cap, upd, wsi, wbr);
        @(posedge clk);
        #1;
        WRST = rst; SelectWIR = sel; ShiftWR = sh; CaptureWR = cap;
        UpdateWR = upd; WSI = wsi; wbr_so = wbr;
        if (rst) model_reset();
        sb.push_back(expect_now(sel, wbr));
        if (!rst) model_step(sel, sh, cap, upd, wsi);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("WSO", WSO, e.wso);
                check("wir_out", wir_out, e.wo);
                check("bypass_sel", bypass_sel, e.byp);
                check("extest_sel", extest_sel, e.ext);
                check("intest_sel", intest_sel, e.intst);
                check("invalid", invalid, e.inv);
                check("len_err", len_err, e.le);
            end
        end
    end

    task automatic load_code(input bit b0, b1, b2);
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, b0, 0);
        drive(0, 1, 1, 0, 0, b1, 0);
        drive(0, 1, 1, 0, 0, b2, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        // reset then idle
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        // extest: WSI bits 1,0,0; WSO shows captured bits during shifts
        load_code(1, 0, 0);
        // reserved code 111
        load_code(1, 1, 1);
        // bypass path with stream 1,0,1,1
        load_code(0, 0, 0);
        drive(0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 1, 1);
        // intest: WSO follows wbr_so
        load_code(0, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, 1, i[0]);
        // short shift then full shift
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        load_code(1, 0, 0);
        // capture+shift+update together
        drive(0, 1, 1, 1, 1, 1, 0);
        drive(0, 1, 1, 0, 1, 1, 0);
        // reset after 2 of 3 shifts, then resume
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 1));
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
